// File: rtl/seq_multiply_add.sv
// Sequential shift-add multiplier: product = multiplicand * multiplier + addend.
// Optional macro SEQ_MULT_OVF_FLAG_EN adds an ovf output for results above WIDTH bits.
module seq_multiply_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef SEQ_MULT_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [PW-1:0]    r_product;

    logic [PW-1:0]    w_mcand_ext;
    logic [PW-1:0]    w_term;
    logic [PW-1:0]    w_sum;
    logic             w_last;
    logic             w_accept;

    assign w_mcand_ext = {{WIDTH{1'b0}}, r_mcand};
    assign w_term      = r_mplier[0] ? (w_mcand_ext << r_count) : '0;
    assign w_sum       = r_acc + w_term;
    assign w_last      = (r_count == CW'(WIDTH - 1));
    // A new request is taken both from IDLE and from the DONE cycle
    assign w_accept    = start && (r_state != S_RUN);

`ifdef SEQ_MULT_OVF_FLAG_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
`ifdef SEQ_MULT_OVF_FLAG_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_mcand  <= multiplicand;
                        r_mplier <= multiplier;
                        r_acc    <= {{WIDTH{1'b0}}, addend};
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_product <= w_sum;
`ifdef SEQ_MULT_OVF_FLAG_EN
                        r_ovf     <= |w_sum[PW-1:WIDTH];
`endif
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiply_add.sv
// Directed bench for seq_multiply_add (WIDTH=4).
// Covers latency, held product, ignored start, back-to-back and async reset.
module tb_seq_multiply_add;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic [3:0] addend = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;
`ifdef SEQ_MULT_OVF_FLAG_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic seen;

    seq_multiply_add #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .done         (done),
        .product      (product)
`ifdef SEQ_MULT_OVF_FLAG_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ovf(input string tag, input logic [7:0] exp_p);
`ifdef SEQ_MULT_OVF_FLAG_EN
        chk(tag, {15'd0, ovf}, {15'd0, (exp_p[7:4] != 4'd0)});
`else
        if (tag == "") $display("unused %0h", exp_p);
`endif
    endtask

    // Present operands with start for one edge, then scramble the inputs
    task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~a;
        multiplier   = ~b;
        addend       = ~c;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] c,
                             input logic [7:0] held, input logic [7:0] exp);
        int n;
        start_op(a, b, c);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
        chk({tag, "_held"}, {8'd0, product}, {8'd0, held});
        wait_done(n);
        chk({tag, "_lat"}, n[15:0], 16'd4);
        chk({tag, "_prod"}, {8'd0, product}, {8'd0, exp});
        chk_ovf({tag, "_ovf"}, exp);
        @(negedge clk);
        chk({tag, "_dlow"}, {14'd0, busy, done}, 16'd0);
        chk({tag, "_hold"}, {8'd0, product}, {8'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", {6'd0, busy, done, product}, 16'd0);
        chk_ovf("rst_ovf", 8'h00);
        rst = 1'b0;
        @(negedge clk);

        run_check("zero", 4'd0, 4'd5, 4'd0, 8'h00, 8'h00);
        run_check("t1", 4'd5, 4'd3, 4'd2, 8'h00, 8'h11);
        run_check("t2a", 4'd3, 4'd2, 4'd1, 8'h11, 8'h07);
        run_check("t2b", 4'd15, 4'd15, 4'd15, 8'h07, 8'hF0);
        run_check("t3", 4'd9, 4'd0, 4'd4, 8'hF0, 8'h04);

        // Start during RUN must be ignored
        start_op(4'd6, 4'd6, 4'd1);
        @(negedge clk);
        multiplicand = 4'd15;
        multiplier   = 4'd15;
        addend       = 4'd15;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(lat);
        chk("t4_lat", lat[15:0], 16'd2);
        chk("t4_prod", {8'd0, product}, 16'h0025);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= done;
        end
        chk("t4_nodone", {15'd0, seen}, 16'd0);

        // Back-to-back from the DONE cycle
        start_op(4'd5, 4'd3, 4'd2);
        wait_done(lat);
        chk("t5_first", {8'd0, product}, 16'h0011);
        multiplicand = 4'd2;
        multiplier   = 4'd7;
        addend       = 4'd0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        chk("t5_nogap", {14'd0, busy, done}, 16'd2);
        chk("t5_held", {8'd0, product}, 16'h0011);
        wait_done(lat);
        chk("t5_lat", lat[15:0], 16'd4);
        chk("t5_prod", {8'd0, product}, 16'h000E);
        chk_ovf("t5_ovf", 8'h0E);

        // Asynchronous reset in the middle of RUN
        start_op(4'd9, 4'd9, 4'd9);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst", {6'd0, busy, done, product}, 16'd0);
        chk_ovf("t6_ovf", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("t6_quiet", {15'd0, seen}, 16'd0);
        run_check("t6_new", 4'd5, 4'd3, 4'd2, 8'h00, 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
